// File: rtl/ov7670_sccb_config.sv
// ============================================================================
// Module   : ov7670_sccb_config
// Brief    : Writes a fixed OV7670 register table over a 3-phase SCCB bus.
//            Optional soft-reset write enabled by macro OV7670_SOFT_RESET_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_sccb_config #(
  parameter int CLK_DIV    = 125,
  parameter int GAP_CYCLES = 500,
  parameter int RST_WAIT   = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  output logic       SDIOC,
  output logic       SDIOD,
  output logic       SDIOD_oe,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int QW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_MAX = (GAP_CYCLES > RST_WAIT) ? GAP_CYCLES : RST_WAIT;
  localparam int WW       = $clog2(WAIT_MAX + 1);

  localparam logic [QW-1:0] Q_LAST   = QW'(CLK_DIV - 1);
  localparam logic [WW-1:0] GAP_LAST = WW'(GAP_CYCLES - 1);
`ifdef OV7670_SOFT_RESET_EN
  localparam logic [WW-1:0] RST_LAST = WW'(RST_WAIT - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_START = 4'd2,
    S_BIT   = 4'd3,
    S_ACKX  = 4'd4,
    S_STOP  = 4'd5,
    S_GAP   = 4'd6,
    S_NEXT  = 4'd7,
    S_DONE  = 4'd8,
    S_RWAIT = 4'd9
  } state_t;

  state_t          state_q;
  logic [QW-1:0]   qcnt_q;
  logic [1:0]      quarter_q;
  logic [2:0]      bit_q;
  logic [1:0]      byte_q;
  logic [1:0]      idx_q;
  logic [23:0]     frame_q;
  logic [WW-1:0]   wait_q;
  logic            scl_q, sda_q, oe_q;
  logic            ocupado_q, pronto_q;
`ifdef OV7670_SOFT_RESET_EN
  logic            soft_q;
`endif

  logic            qtick;
  logic            bit_end;
  logic [15:0]     tbl_entry;
  logic [23:0]     frame_d;
  logic            scl_d, sda_d, oe_d;

  assign qtick   = (qcnt_q == Q_LAST);
  assign bit_end = qtick && (quarter_q == 2'd3);

  always_comb begin
    tbl_entry = 16'h120C;
    case (idx_q)
      2'd0:    tbl_entry = 16'h120C;
      2'd1:    tbl_entry = 16'h40D0;
      2'd2:    tbl_entry = 16'h1101;
      default: tbl_entry = 16'h0C08;
    endcase
    frame_d = {8'h42, tbl_entry};
`ifdef OV7670_SOFT_RESET_EN
    if (soft_q) frame_d = 24'h421280;
`endif
  end

  // Bus levels derived from the current phase; registered below, so the whole
  // waveform is shifted by one clock but every quarter keeps its length.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    oe_d  = 1'b1;
    case (state_q)
      S_START: begin
        scl_d = (quarter_q != 2'd3);
        sda_d = (quarter_q < 2'd2);
      end
      S_BIT: begin
        scl_d = quarter_q[1];
        sda_d = frame_q[23];
      end
      S_ACKX: begin
        scl_d = quarter_q[1];
        oe_d  = 1'b0;
      end
      S_STOP: begin
        scl_d = (quarter_q != 2'd0);
        sda_d = quarter_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      quarter_q <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      wait_q    <= '0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      oe_q      <= 1'b1;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
`ifdef OV7670_SOFT_RESET_EN
      soft_q    <= 1'b0;
`endif
    end else begin
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      oe_q     <= oe_d;
      pronto_q <= 1'b0;

      if ((state_q == S_START) || (state_q == S_BIT) ||
          (state_q == S_ACKX) || (state_q == S_STOP)) begin
        if (qtick) begin
          qcnt_q    <= '0;
          quarter_q <= quarter_q + 2'd1;
        end else begin
          qcnt_q <= qcnt_q + 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (iniciar) begin
            state_q   <= S_LOAD;
            ocupado_q <= 1'b1;
            idx_q     <= '0;
`ifdef OV7670_SOFT_RESET_EN
            soft_q    <= 1'b1;
`endif
          end
        end
        S_LOAD: begin
          frame_q   <= frame_d;
          qcnt_q    <= '0;
          quarter_q <= '0;
          bit_q     <= '0;
          byte_q    <= '0;
          state_q   <= S_START;
        end
        S_START: begin
          if (bit_end) state_q <= S_BIT;
        end
        S_BIT: begin
          if (bit_end) begin
            frame_q <= {frame_q[22:0], 1'b0};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_ACKX;
          end
        end
        S_ACKX: begin
          if (bit_end) begin
            if (byte_q == 2'd2) begin
              byte_q  <= '0;
              state_q <= S_STOP;
            end else begin
              byte_q  <= byte_q + 2'd1;
              state_q <= S_BIT;
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            wait_q  <= '0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (wait_q == GAP_LAST) begin
            wait_q  <= '0;
            state_q <= S_NEXT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_NEXT: begin
`ifdef OV7670_SOFT_RESET_EN
          if (soft_q) begin
            soft_q  <= 1'b0;
            wait_q  <= '0;
            state_q <= S_RWAIT;
          end else
`endif
          if (idx_q == 2'd3) begin
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= S_LOAD;
          end
        end
`ifdef OV7670_SOFT_RESET_EN
        S_RWAIT: begin
          if (wait_q == RST_LAST) begin
            wait_q  <= '0;
            state_q <= S_LOAD;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
`endif
        S_DONE: begin
          if (!iniciar) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign SDIOC     = scl_q;
  assign SDIOD     = sda_q;
  assign SDIOD_oe  = oe_q;
  assign ocupado   = ocupado_q;
  assign pronto    = pronto_q;
  assign db_estado = state_q;

endmodule

`default_nettype wire

// File: doc/ov7670_sccb_config.md
OV7670_SCCB_CONFIG -- requirements
Module: ov7670_sccb_config

Interface
REQ-001 Parameter CLK_DIV, default 125: clock cycles per quarter SCCB bit period (100 kHz SCCB at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 500: idle cycles between consecutive register writes.
REQ-003 Parameter RST_WAIT, default 50000: wait cycles after the soft-reset write (only when the soft-reset feature is compiled in).
REQ-004 Port clock, input, 1: the single clock for the block.
REQ-005 Port reset, input, 1: synchronous, active-high.
REQ-006 Port iniciar, input, 1: level-sensitive start request; only acted on in IDLE.
REQ-007 Port SDIOC, output, 1: SCCB clock.
REQ-008 Port SDIOD, output, 1: SCCB data value.
REQ-009 Port SDIOD_oe, output, 1: SDIOD drive enable.
  - 1 = drive SDIOD.
  - 0 = release SDIOD during the 9th (don't-care) bit.
REQ-010 Port ocupado, input/output n/a; output, 1: high from leaving IDLE until entering DONE.
REQ-011 Port pronto, output, 1: single-cycle pulse on entering DONE.
REQ-012 Port db_estado, output, 4: current state code.

Function
REQ-013 The block SHALL write an internal fixed table, in order, as 3-phase SCCB writes to device ID 0x42. Table:
  - 0: 0x12←0x0C
  - 1: 0x40←0xD0
  - 2: 0x11←0x01
  - 3: 0x0C←0x08
REQ-014 State codes SHALL be:
  - IDLE=0, LOAD=1, START=2, BIT=3, ACKX=4, STOP=5, GAP=6, NEXT=7, DONE=8, RWAIT=9.
REQ-015 Transitions SHALL be:
  - IDLE→LOAD when iniciar=1.
  - LOAD→START after 1 cycle; LOAD latches the 24-bit frame {0x42, addr, data}.
  - START→BIT.
  - BIT→ACKX after 8 bits of a byte.
  - ACKX→BIT if bytes remain, else ACKX→STOP.
  - STOP→GAP.
  - GAP→NEXT after GAP_CYCLES.
  - NEXT→LOAD if entries remain, else NEXT→DONE.
  - DONE→IDLE when iniciar=0.
REQ-016 Every SCCB bit SHALL last 4 quarters of CLK_DIV cycles each.
  - SDIOC is low in quarters 0–1 and high in quarters 2–3.
  - SDIOD changes only at the start of quarter 0.
REQ-017 START SHALL take 4 quarters:
  - SDIOD=1 and SDIOC=1 for quarters 0–1.
  - SDIOD=0 with SDIOC=1 at quarter 2.
  - SDIOC=0 at quarter 3.
REQ-018 STOP SHALL take 4 quarters:
  - SDIOD=0 and SDIOC low for quarter 0.
  - SDIOC=1 at quarter 1.
  - SDIOD=1 at quarter 2 and held.
REQ-019 Bits SHALL be sent MSB first.
REQ-020 During ACKX, SDIOD_oe=0 and SDIOD=1; the slave response SHALL be ignored.
REQ-021 In IDLE, GAP and DONE: SDIOC=1, SDIOD=1, SDIOD_oe=1.
REQ-022 Transaction timing, excluding LOAD/NEXT cycles:
  - One write = (1 start + 27 data/ack bits + 1 stop) × 4×CLK_DIV cycles.
  - Followed by GAP_CYCLES idle cycles.
REQ-023 iniciar asserted while ocupado=1 SHALL be ignored; the sequence never restarts mid-table.
REQ-024 The quarter counter SHALL be ceil(log2(CLK_DIV)) bits and SHALL wrap to 0 at CLK_DIV-1.
REQ-025 The bit counter (0–7) SHALL wrap at 7.
REQ-026 The table index SHALL saturate at the last entry; no wrap to entry 0.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL enter IDLE with:
  - SDIOC=1, SDIOD=1, SDIOD_oe=1.
  - ocupado=0, pronto=0, db_estado=0.
  - All counters and the table index at 0.
REQ-028 A reset mid-transaction SHALL abort without emitting STOP.
  - The bus returns to idle-high on the next edge.
  - A later iniciar restarts from table entry 0.

Configuration
REQ-029 Macro OV7670_SOFT_RESET_EN.
  - Defined: before entry 0, the block SHALL write 0x12←0x80, then hold RWAIT for RST_WAIT cycles (bus idle-high), then proceed to LOAD of entry 0.
  - Undefined: RWAIT is unreachable, no soft-reset write occurs, and the first transaction is entry 0.

Verification (CLK_DIV=2, GAP_CYCLES=4, RST_WAIT=10)
REQ-030 Reset, then iniciar pulse → expected response:
  - First SDIOD fall occurs while SDIOC=1.
  - Sampled bytes are 0x42, 0x12, 0x0C.
  - SDIOD_oe=0 on bits 9, 18 and 27.
REQ-031 Full run → 4 transactions (addr 0x12, 0x40, 0x11, 0x0C) → pronto pulses exactly once for 1 cycle; ocupado=0 afterwards.
REQ-032 iniciar held high through DONE → block stays in DONE (db_estado=8) until iniciar=0, then IDLE.
REQ-033 iniciar re-pulsed during transaction 2 → no restart; exactly 4 transactions are observed.
REQ-034 reset asserted mid-byte of transaction 1 → next cycle SDIOC=1, SDIOD=1, db_estado=0; new iniciar → transaction starts at 0x12←0x0C.
REQ-035 With OV7670_SOFT_RESET_EN defined → first write is 0x12←0x80, followed by ≥10 idle cycles, then 0x12←0x0C.
